// File: rtl/main_memory_responder_pkg.sv
// ----------------------------------------------------------------------------
// main_memory_responder_pkg
//   Shared constants and types for the MainBus main-memory responder and the
//   caches that talk to it: block size, bus address type, default access
//   latency, responder state encoding and the power-up image helper.
// ----------------------------------------------------------------------------
package main_memory_responder_pkg;

    localparam int unsigned BLOCKBYTES  = 4;
    localparam int unsigned ADDRBITS    = 16;
    localparam int unsigned MEM_DEPTH   = 256;
    localparam int unsigned MEM_LATENCY = 4;

    typedef logic [ADDRBITS-1:0] address_t;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        IDLE    = 3'd1,
        RD_WAIT = 3'd2,
        WR_WAIT = 3'd3,
        GAP     = 3'd4
    } memstate_t;

    // Byte b of block k in the power-up image is the low byte of its linear
    // byte address, so every location is distinguishable in a fresh memory.
    function automatic logic [7:0] pattern_byte(
        input int unsigned blk,
        input int unsigned bytes_per_block,
        input int unsigned byte_pos
    );
        int unsigned lin;
        lin = (blk * bytes_per_block) + byte_pos;
        return lin[7:0];
    endfunction

endpackage

// File: rtl/main_memory_block_ram.sv
// ----------------------------------------------------------------------------
// main_memory_block_ram
//   Single-port block storage: DEPTH entries of WIDTH bits, synchronous write,
//   registered read (read-before-write on a colliding address).
// Ports
//   clock  in   rising-edge clock
//   we     in   write enable for this edge
//   addr   in   block index (read and write share the port)
//   wdata  in   block to store when we is high
//   rdata  out  block at addr, registered
// ----------------------------------------------------------------------------
module main_memory_block_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage array write port; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clock) begin
        rdata <= mem_r[addr];
    end

endmodule

// File: rtl/main_memory_responder.sv
// ----------------------------------------------------------------------------
// main_memory_responder
//   Main-memory end of the MainBus block-transfer protocol. Answers whole-block
//   READ (line fill) and WRITE (write-back) requests after a fixed latency and
//   loads a known image into storage after every reset.
// Ports
//   clock    in   rising-edge clock
//   reset    in   synchronous, active-high
//   address  in   byte address; block offset bits and bits above the index ignored
//   READ     in   block read request, held until ACK
//   WRITE    in   block write request, held until ACK (wins over READ)
//   DataOut  in   write block from cache, byte i at [8i+7:8i]
//   DataIn   out  read block to cache, updated only on a read ACK
//   ACK      out  one-cycle completion pulse
//   BUSY     out  high while the power-up image is being written
// ----------------------------------------------------------------------------
module main_memory_responder #(
    parameter int unsigned BLOCKBYTES   = main_memory_responder_pkg::BLOCKBYTES,
    parameter int unsigned ADDRBITS     = main_memory_responder_pkg::ADDRBITS,
    parameter int unsigned DEPTH        = main_memory_responder_pkg::MEM_DEPTH,
    parameter int unsigned LATENCY      = main_memory_responder_pkg::MEM_LATENCY,
    parameter int unsigned INIT_PATTERN = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDRBITS-1:0]     address,
    input  logic                    READ,
    input  logic                    WRITE,
    input  logic [BLOCKBYTES*8-1:0] DataOut,
    output logic [BLOCKBYTES*8-1:0] DataIn,
    output logic                    ACK,
    output logic                    BUSY
);

    import main_memory_responder_pkg::*;

    localparam int unsigned OFF   = $clog2(BLOCKBYTES);
    localparam int unsigned IDXW  = $clog2(DEPTH);
    localparam int unsigned WIDTH = BLOCKBYTES * 8;
    localparam int unsigned CNTW  = 4;

    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DEPTH - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [CNTW-1:0] LAT_LOAD = CNTW'(LATENCY - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    memstate_t         state_r;
    logic [IDXW-1:0]   init_idx_r;
    logic [CNTW-1:0]   cnt_r;
    logic [IDXW-1:0]   idx_r;
    logic [WIDTH-1:0]  wdata_r;

    logic [IDXW-1:0]   req_idx_s;
    logic [WIDTH-1:0]  init_block_s;
    logic              ram_we_s;
    logic [IDXW-1:0]   ram_addr_s;
    logic [WIDTH-1:0]  ram_wdata_s;
    logic [WIDTH-1:0]  ram_rdata_s;
    logic              unused_addr_bits_s;

    // Block index straight from the bus; offset and upper bits play no part.
    assign req_idx_s          = address[OFF+IDXW-1:OFF];
    assign unused_addr_bits_s = ^{address[ADDRBITS-1:OFF+IDXW], address[OFF-1:0]};

    // Power-up image for the block currently being initialised.
    always_comb begin
        init_block_s = '0;
        for (int unsigned b = 0; b < BLOCKBYTES; b++) begin
            if (INIT_PATTERN != 0) begin
                init_block_s[8*b +: 8] = pattern_byte(32'(init_idx_r), BLOCKBYTES, b);
            end else begin
                init_block_s[8*b +: 8] = 8'h00;
            end
        end
    end

    // Storage port steering. In IDLE the incoming index is presented so the
    // registered read is already valid one edge after acceptance, which lets a
    // latency of 1 use the same ACK path. Writes are suppressed under reset so
    // an aborted write-back never reaches storage.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_addr_s  = idx_r;
        ram_wdata_s = wdata_r;
        case (state_r)
            INIT: begin
                ram_we_s    = ~reset;
                ram_addr_s  = init_idx_r;
                ram_wdata_s = init_block_s;
            end
            IDLE: begin
                ram_addr_s = req_idx_s;
            end
            WR_WAIT: begin
                ram_we_s = (~reset) & (cnt_r == {CNTW{1'b0}});
            end
            default: begin
                ram_we_s = 1'b0;
            end
        endcase
    end

    main_memory_block_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clock (clock),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // Responder FSM: initialisation sweep, request acceptance, latency count,
    // ACK/DataIn generation and the one-cycle post-ACK gap.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= INIT;
            init_idx_r <= '0;
            cnt_r      <= '0;
            idx_r      <= '0;
            wdata_r    <= '0;
            DataIn     <= '0;
            ACK        <= 1'b0;
            BUSY       <= 1'b1;
        end else begin
            ACK <= 1'b0;
            case (state_r)
                INIT: begin
                    if (init_idx_r == IDX_LAST) begin
                        state_r <= IDLE;
                        BUSY    <= 1'b0;
                    end else begin
                        init_idx_r <= init_idx_r + IDX_ONE;
                    end
                end
                IDLE: begin
                    if (WRITE) begin
                        state_r <= WR_WAIT;
                        idx_r   <= req_idx_s;
                        wdata_r <= DataOut;
                        cnt_r   <= LAT_LOAD;
                    end else if (READ) begin
                        state_r <= RD_WAIT;
                        idx_r   <= req_idx_s;
                        cnt_r   <= LAT_LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (cnt_r == {CNTW{1'b0}}) begin
                        ACK     <= 1'b1;
                        DataIn  <= ram_rdata_s;
                        state_r <= GAP;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                WR_WAIT: begin
                    // Storage commits on this same edge through ram_we_s.
                    if (cnt_r == {CNTW{1'b0}}) begin
                        ACK     <= 1'b1;
                        state_r <= GAP;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                GAP: begin
                    state_r <= IDLE;
                end
                default: begin
                    // Unreachable encoding: rebuild the image from scratch.
                    state_r    <= INIT;
                    init_idx_r <= '0;
                    BUSY       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_memory_responder.sv
// ----------------------------------------------------------------------------
// tb_main_memory_responder
//   Scoreboard bench for main_memory_responder. The main instance uses the
//   default build (DEPTH 256, LATENCY 4); a second, small instance uses
//   LATENCY 1 for the back-to-back request case.
// ----------------------------------------------------------------------------
module tb_main_memory_responder;

    localparam int LAT0        = 4;
    localparam int DEPTH0      = 256;
    localparam int ACK_BUDGET  = 64;
    localparam int INIT_BUDGET = 1000;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] address0;
    logic        read0;
    logic        write0;
    logic [31:0] dataout0;
    logic [31:0] datain0;
    logic        ack0;
    logic        busy0;

    logic [15:0] address1;
    logic        read1;
    logic        write1;
    logic [31:0] dataout1;
    logic [31:0] datain1;
    logic        ack1;
    logic        busy1;

    exp_t sb_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    always #5 clock = ~clock;

    main_memory_responder #(
        .DEPTH        (DEPTH0),
        .LATENCY      (LAT0),
        .INIT_PATTERN (1)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .address (address0),
        .READ    (read0),
        .WRITE   (write0),
        .DataOut (dataout0),
        .DataIn  (datain0),
        .ACK     (ack0),
        .BUSY    (busy0)
    );

    main_memory_responder #(
        .DEPTH        (16),
        .LATENCY      (1),
        .INIT_PATTERN (1)
    ) dut_lat1 (
        .clock   (clock),
        .reset   (reset),
        .address (address1),
        .READ    (read1),
        .WRITE   (write1),
        .DataOut (dataout1),
        .DataIn  (datain1),
        .ACK     (ack1),
        .BUSY    (busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pop the oldest expectation and compare read data against it.
    task automatic score_ack(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            if (e.is_read) begin
                check({tag, "_data"}, datain0, e.data);
            end
        end
    endtask

    // Wait (bounded) for ACK on the main instance, scoring it when it comes.
    task automatic wait_ack(input string tag, output int cycles);
        cycles = 0;
        while (cycles < ACK_BUDGET) begin
            @(negedge clock);
            cycles++;
            if (ack0) break;
        end
        if (!ack0) begin
            check({tag, "_ack_timeout"}, 32'd0, 32'd1);
            cycles = -1;
        end else begin
            score_ack(tag);
        end
    endtask

    // Wait (bounded) for BUSY to fall; returns the number of edges it took.
    task automatic wait_init(output int cycles);
        cycles = 0;
        while (cycles < INIT_BUDGET) begin
            @(negedge clock);
            cycles++;
            if (!busy0) break;
        end
    endtask

    // One full transaction from IDLE: push expectation, request, check
    // latency, drop request, check the ACK pulse is a single cycle.
    task automatic run_txn(input logic is_write, input logic [15:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp,
                           input string tag);
        exp_t e;
        int   cyc;
        e.is_read = ~is_write;
        e.data    = exp;
        sb_q.push_back(e);
        address0 = addr;
        dataout0 = wdata;
        write0   = is_write;
        read0    = ~is_write;
        wait_ack(tag, cyc);
        if (cyc > 0) begin
            check({tag, "_latency"}, 32'(cyc - 1), 32'(LAT0));
        end
        write0 = 1'b0;
        read0  = 1'b0;
        @(negedge clock);
        check({tag, "_ack_width"}, {31'd0, ack0}, 32'd0);
    endtask

    initial begin
        int   n;
        int   cyc;
        int   acks;
        int   ack_t[$];
        exp_t e;

        reset    = 1'b1;
        address0 = 16'h0000;
        read0    = 1'b0;
        write0   = 1'b0;
        dataout0 = 32'h0000_0000;
        address1 = 16'h0000;
        read1    = 1'b0;
        write1   = 1'b0;
        dataout1 = 32'h0000_0000;

        // ---- 1: reset values, init duration, first read ----
        repeat (3) @(negedge clock);
        check("rst_datain", datain0, 32'h0000_0000);
        check("rst_ack",    {31'd0, ack0},  32'd0);
        check("rst_busy",   {31'd0, busy0}, 32'd1);
        reset = 1'b0;
        wait_init(n);
        check("busy_cycles", 32'(n), 32'(DEPTH0));
        check("lat1_busy_done", {31'd0, busy1}, 32'd0);
        run_txn(1'b0, 16'h0014, 32'h0, 32'h1716_1514, "t1_read");

        // ---- 2: write then read back; DataIn holds across a write ----
        run_txn(1'b1, 16'h0020, 32'hDEAD_BEEF, 32'h0, "t2_write");
        check("t2_datain_hold", datain0, 32'h1716_1514);
        run_txn(1'b0, 16'h0020, 32'h0, 32'hDEAD_BEEF, "t2_read");

        // ---- 3: READ and WRITE together, write first, read pending ----
        e.is_read = 1'b0; e.data = 32'h0;          sb_q.push_back(e);
        e.is_read = 1'b1; e.data = 32'h0102_0304;  sb_q.push_back(e);
        address0 = 16'h0040;
        dataout0 = 32'h0102_0304;
        write0   = 1'b1;
        read0    = 1'b1;
        wait_ack("t3_first", cyc);
        check("t3_first_latency", 32'(cyc - 1), 32'(LAT0));
        write0 = 1'b0;
        wait_ack("t3_second", cyc);
        read0 = 1'b0;
        acks = 0;
        repeat (10) begin
            @(negedge clock);
            if (ack0) acks++;
        end
        check("t3_extra_acks", 32'(acks), 32'd0);

        // ---- 4: address/data changes during WR_WAIT are ignored ----
        e.is_read = 1'b0; e.data = 32'h0; sb_q.push_back(e);
        address0 = 16'h0030;
        dataout0 = 32'h1111_1111;
        write0   = 1'b1;
        @(negedge clock);
        address0 = 16'h0034;
        dataout0 = 32'h2222_2222;
        wait_ack("t4_write", cyc);
        write0 = 1'b0;
        @(negedge clock);
        run_txn(1'b0, 16'h0030, 32'h0, 32'h1111_1111, "t4_read_latched");
        run_txn(1'b0, 16'h0034, 32'h0, 32'h3736_3534, "t4_read_other");

        // ---- 6: LATENCY=1 build, READ held high -> ACK every 3 cycles ----
        address1 = 16'h0004;
        read1    = 1'b1;
        n = 0;
        while (n < 40 && ack_t.size() < 3) begin
            @(negedge clock);
            n++;
            if (ack1) begin
                ack_t.push_back(n);
                check("t6_data", datain1, 32'h0706_0504);
            end
        end
        read1 = 1'b0;
        check("t6_ack_count", 32'(ack_t.size()), 32'd3);
        if (ack_t.size() == 3) begin
            check("t6_first_latency", 32'(ack_t[0] - 1), 32'd1);
            check("t6_interval_a", 32'(ack_t[1] - ack_t[0]), 32'd3);
            check("t6_interval_b", 32'(ack_t[2] - ack_t[1]), 32'd3);
        end

        // ---- 5: reset two cycles into WR_WAIT aborts the write ----
        repeat (3) @(negedge clock);
        address0 = 16'h0008;
        dataout0 = 32'hCAFE_F00D;
        write0   = 1'b1;
        acks = 0;
        repeat (2) begin
            @(negedge clock);
            if (ack0) acks++;
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clock);
            if (ack0) acks++;
        end
        check("t5_no_ack", 32'(acks), 32'd0);
        check("t5_busy_in_reset", {31'd0, busy0}, 32'd1);
        write0 = 1'b0;
        reset  = 1'b0;
        wait_init(n);
        check("t5_reinit_cycles", 32'(n), 32'(DEPTH0));
        run_txn(1'b0, 16'h0008, 32'h0, 32'h0B0A_0908, "t5_read");
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
